// File: rtl/dm_pkg.sv
// Shared definitions for the DMI debug module.
//   - DM register addresses on the DMI bus
//   - abstractcs.cmderr encodings
//   - dmcontrol / command field bit positions
//   - abstract command FSM state type
//   - helpers that assemble the read-only status words
package dm_pkg;

    localparam logic [6:0] DM_DATA0      = 7'h04;
    localparam logic [6:0] DM_DMCONTROL  = 7'h10;
    localparam logic [6:0] DM_DMSTATUS   = 7'h11;
    localparam logic [6:0] DM_ABSTRACTCS = 7'h16;
    localparam logic [6:0] DM_COMMAND    = 7'h17;

    localparam logic [2:0] CMDERR_NONE       = 3'd0;
    localparam logic [2:0] CMDERR_BUSY       = 3'd1;
    localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
    localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

    localparam int DMC_HALTREQ   = 31;
    localparam int DMC_RESUMEREQ = 30;
    localparam int DMC_NDMRESET  = 1;
    localparam int DMC_DMACTIVE  = 0;

    localparam int CMD_TYPE_LSB    = 24;
    localparam int CMD_AARSIZE_LSB = 20;
    localparam int CMD_TRANSFER    = 17;
    localparam int CMD_WRITE       = 16;

    localparam logic [2:0]  AARSIZE_32    = 3'd2;
    // GPRs x0..x31 live at regno 0x1000..0x101F: upper bits fixed, low 5 bits index
    localparam logic [10:0] REGNO_GPR_HI  = 11'h080;

    typedef enum logic {
        ABS_IDLE = 1'b0,
        ABS_REQ  = 1'b1
    } abs_state_e;

    function automatic logic [31:0] dmstatus_word(input logic halted, input logic resumeack);
        logic [31:0] w;
        w       = 32'd0;
        w[3:0]  = 4'd2;
        w[7]    = 1'b1;
        w[8]    = halted;
        w[9]    = halted;
        w[10]   = !halted;
        w[11]   = !halted;
        w[16]   = resumeack;
        w[17]   = resumeack;
        return w;
    endfunction

    function automatic logic [31:0] abstractcs_word(input logic busy, input logic [2:0] cmderr);
        logic [31:0] w;
        w       = 32'd0;
        w[3:0]  = 4'd1;
        w[10:8] = cmderr;
        w[12]   = busy;
        return w;
    endfunction

endpackage

// File: rtl/dmi_debug_module_if.sv
// DMI request/response bundle between the debug transport (master) and
// the debug module (slave).
//   dmi_valid  one-cycle request strobe
//   dmi_wr     1 = write, 0 = read
//   dmi_addr   DM register address
//   dmi_wdata  write data
//   dmi_rdata  registered read data, held until the next read
interface dmi_debug_module_if;
    logic        dmi_valid;
    logic        dmi_wr;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata;
    logic [31:0] dmi_rdata;

    modport master (
        output dmi_valid, dmi_wr, dmi_addr, dmi_wdata,
        input  dmi_rdata
    );

    modport slave (
        input  dmi_valid, dmi_wr, dmi_addr, dmi_wdata,
        output dmi_rdata
    );
endinterface

// File: rtl/dm_abstract.sv
// Abstract command engine: validates command writes, owns abstractcs.cmderr,
// and runs the IDLE/REQ FSM that drives the GPR access handshake.
//   kill        clear everything (DM inactive or being deactivated)
//   cmd_wr      command register write, cmd_wdata its value
//   cs_wr       abstractcs write, cs_w1c the cmderr write-1-to-clear bits
//   data0_wr    data0 write (an error while busy)
//   data0       current data0, captured as ar_wdata at launch
//   busy        abstractcs.busy
//   cmderr      abstractcs.cmderr
//   ar_*        GPR access port to the core
//   load_data0  completed read: top loads data0 from ar_rdata
module dm_abstract
    import dm_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        kill,
    input  logic        hart_halted,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_wdata,
    input  logic        cs_wr,
    input  logic [2:0]  cs_w1c,
    input  logic        data0_wr,
    input  logic [31:0] data0,
    input  logic        ar_ready,
    output logic        busy,
    output logic [2:0]  cmderr,
    output logic        ar_valid,
    output logic        ar_write,
    output logic [4:0]  ar_regno,
    output logic [31:0] ar_wdata,
    output logic        load_data0
);

    abs_state_e  state_q, state_n;
    logic [2:0]  cmderr_q, cmderr_n;
    logic        launch;
    logic        cmd_supported;
    logic        cmd_unused;

    // Command bits 23 and 19:18 carry no function in this subset
    assign cmd_unused = ^{cmd_wdata[23], cmd_wdata[19:18]};

    assign cmd_supported = (cmd_wdata[CMD_TYPE_LSB +: 8] == 8'd0)
                        && (cmd_wdata[CMD_AARSIZE_LSB +: 3] == AARSIZE_32)
                        && (cmd_wdata[15:5] == REGNO_GPR_HI);

    assign busy       = (state_q == ABS_REQ);
    assign cmderr     = cmderr_q;
    assign ar_valid   = busy;
    assign load_data0 = busy && ar_ready && !ar_write && !kill;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ABS_IDLE;
            cmderr_q <= CMDERR_NONE;
        end else begin
            state_q  <= state_n;
            cmderr_q <= cmderr_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        cmderr_n = cmderr_q;
        launch   = 1'b0;
        if (kill) begin
            state_n  = ABS_IDLE;
            cmderr_n = CMDERR_NONE;
        end else begin
            if (state_q == ABS_REQ && ar_ready)
                state_n = ABS_IDLE;

            // a sticky error blocks all further commands until cleared
            if (cmd_wr && cmderr_q == CMDERR_NONE) begin
                if (state_q == ABS_REQ)
                    cmderr_n = CMDERR_BUSY;
                else if (!cmd_supported)
                    cmderr_n = CMDERR_NOTSUP;
                else if (!hart_halted)
                    cmderr_n = CMDERR_HALTRESUME;
                else if (cmd_wdata[CMD_TRANSFER]) begin
                    launch  = 1'b1;
                    state_n = ABS_REQ;
                end
            end

            if (data0_wr && state_q == ABS_REQ && cmderr_q == CMDERR_NONE)
                cmderr_n = CMDERR_BUSY;

            if (cs_wr)
                cmderr_n = cmderr_q & ~cs_w1c;
        end
    end

    // Access descriptor is captured once at launch and held through REQ
    always_ff @(posedge clk) begin
        if (!resetn || kill) begin
            ar_write <= 1'b0;
            ar_regno <= 5'd0;
            ar_wdata <= 32'd0;
        end else if (launch) begin
            ar_write <= cmd_wdata[CMD_WRITE];
            ar_regno <= cmd_wdata[4:0];
            ar_wdata <= data0;
        end
    end

endmodule

// File: rtl/dmi_debug_module.sv
// Minimal RISC-V Debug Module (0.13 subset, one hart) on the responder side
// of the DMI bus. Implements data0, dmcontrol, dmstatus, abstractcs, command.
// Optional feature macro: DM_NDMRESET_EN makes dmcontrol.ndmreset RW and
// drives the ndmreset port; otherwise the bit reads 0 and ndmreset is 0.
//   clk, resetn      clock, synchronous active-low reset
//   dmi              DMI slave port (request strobe, addr, data, held rdata)
//   hart_halted      core is in debug mode
//   halt_req         level, mirrors dmcontrol.haltreq
//   resume_req       level, held until the hart leaves debug mode
//   ar_valid/ar_write/ar_regno/ar_wdata/ar_ready/ar_rdata  GPR access port
//   ndmreset         system reset request
module dmi_debug_module
    import dm_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetn,
    dmi_debug_module_if.slave       dmi,
    input  logic                    hart_halted,
    output logic                    halt_req,
    output logic                    resume_req,
    output logic                    ar_valid,
    output logic                    ar_write,
    output logic [4:0]              ar_regno,
    output logic [31:0]             ar_wdata,
    input  logic                    ar_ready,
    input  logic [31:0]             ar_rdata,
    output logic                    ndmreset
);

    logic        dmactive_q;
    logic        haltreq_q;
    logic        ndmreset_q;
    logic        resume_req_q;
    logic        resumeack_q;
    logic [31:0] data0_q;
    logic [31:0] rd_word;

    logic        req_wr, req_rd;
    logic        wr_ctrl, wr_data0, wr_cs, wr_cmd;
    logic        kill;
    logic        busy;
    logic [2:0]  cmderr;
    logic        load_data0;

    assign req_wr  = dmi.dmi_valid && dmi.dmi_wr;
    assign req_rd  = dmi.dmi_valid && !dmi.dmi_wr;
    assign wr_ctrl = req_wr && (dmi.dmi_addr == DM_DMCONTROL);

    // While inactive, or in the cycle dmactive is being cleared, every DM
    // register is forced to 0 and only dmactive itself can change.
    assign kill = !dmactive_q || (wr_ctrl && !dmi.dmi_wdata[DMC_DMACTIVE]);

    assign wr_data0 = req_wr && !kill && (dmi.dmi_addr == DM_DATA0);
    assign wr_cs    = req_wr && !kill && (dmi.dmi_addr == DM_ABSTRACTCS);
    assign wr_cmd   = req_wr && !kill && (dmi.dmi_addr == DM_COMMAND);

    assign halt_req   = haltreq_q;
    assign resume_req = resume_req_q;
    assign ndmreset   = ndmreset_q;

    dm_abstract u_abstract (
        .clk         (clk),
        .resetn      (resetn),
        .kill        (kill),
        .hart_halted (hart_halted),
        .cmd_wr      (wr_cmd),
        .cmd_wdata   (dmi.dmi_wdata),
        .cs_wr       (wr_cs),
        .cs_w1c      (dmi.dmi_wdata[10:8]),
        .data0_wr    (wr_data0),
        .data0       (data0_q),
        .ar_ready    (ar_ready),
        .busy        (busy),
        .cmderr      (cmderr),
        .ar_valid    (ar_valid),
        .ar_write    (ar_write),
        .ar_regno    (ar_regno),
        .ar_wdata    (ar_wdata),
        .load_data0  (load_data0)
    );

    always_ff @(posedge clk) begin
        if (!resetn)
            dmactive_q <= 1'b0;
        else if (wr_ctrl)
            dmactive_q <= dmi.dmi_wdata[DMC_DMACTIVE];
    end

    always_ff @(posedge clk) begin
        if (!resetn || kill)
            haltreq_q <= 1'b0;
        else if (wr_ctrl)
            haltreq_q <= dmi.dmi_wdata[DMC_HALTREQ];
    end

`ifdef DM_NDMRESET_EN
    always_ff @(posedge clk) begin
        if (!resetn || kill)
            ndmreset_q <= 1'b0;
        else if (wr_ctrl)
            ndmreset_q <= dmi.dmi_wdata[DMC_NDMRESET];
    end
`else
    assign ndmreset_q = 1'b0;
`endif

    // A resume request together with a halt request is dropped; otherwise it
    // is held until the hart reports running, which is the acknowledge.
    always_ff @(posedge clk) begin
        if (!resetn || kill) begin
            resume_req_q <= 1'b0;
            resumeack_q  <= 1'b0;
        end else if (wr_ctrl && dmi.dmi_wdata[DMC_RESUMEREQ] && !dmi.dmi_wdata[DMC_HALTREQ]) begin
            resume_req_q <= 1'b1;
            resumeack_q  <= 1'b0;
        end else if (resume_req_q && !hart_halted) begin
            resume_req_q <= 1'b0;
            resumeack_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || kill)
            data0_q <= 32'd0;
        else if (load_data0)
            data0_q <= ar_rdata;
        else if (wr_data0 && !busy)
            data0_q <= dmi.dmi_wdata;
    end

    always_comb begin
        rd_word = 32'd0;
        if (dmactive_q) begin
            case (dmi.dmi_addr)
                DM_DATA0:      rd_word = data0_q;
                DM_DMCONTROL: begin
                    rd_word[DMC_HALTREQ]  = haltreq_q;
                    rd_word[DMC_NDMRESET] = ndmreset_q;
                    rd_word[DMC_DMACTIVE] = dmactive_q;
                end
                DM_DMSTATUS:   rd_word = dmstatus_word(hart_halted, resumeack_q);
                DM_ABSTRACTCS: rd_word = abstractcs_word(busy, cmderr);
                default:       rd_word = 32'd0;
            endcase
        end
    end

    // Read data reflects state before this cycle's write effects
    always_ff @(posedge clk) begin
        if (!resetn)
            dmi.dmi_rdata <= 32'd0;
        else if (req_rd)
            dmi.dmi_rdata <= rd_word;
    end

endmodule

// File: tb/tb_dmi_debug_module.sv
module tb_dmi_debug_module;
    import dm_pkg::*;

    logic        clk;
    logic        resetn;
    logic        hart_halted;
    logic        halt_req;
    logic        resume_req;
    logic        ar_valid;
    logic        ar_write;
    logic [4:0]  ar_regno;
    logic [31:0] ar_wdata;
    logic        ar_ready;
    logic [31:0] ar_rdata;
    logic        ndmreset;

    int checks = 0;
    int errors = 0;

    dmi_debug_module_if dmi_bus();

    dmi_debug_module dut (
        .clk         (clk),
        .resetn      (resetn),
        .dmi         (dmi_bus),
        .hart_halted (hart_halted),
        .halt_req    (halt_req),
        .resume_req  (resume_req),
        .ar_valid    (ar_valid),
        .ar_write    (ar_write),
        .ar_regno    (ar_regno),
        .ar_wdata    (ar_wdata),
        .ar_ready    (ar_ready),
        .ar_rdata    (ar_rdata),
        .ndmreset    (ndmreset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Drive one request starting at a negedge; return at the following
    // negedge, after the DUT has sampled it.
    task automatic dmi_write(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        dmi_bus.dmi_valid = 1'b1;
        dmi_bus.dmi_wr    = 1'b1;
        dmi_bus.dmi_addr  = a;
        dmi_bus.dmi_wdata = d;
        @(negedge clk);
        dmi_bus.dmi_valid = 1'b0;
        dmi_bus.dmi_wr    = 1'b0;
    endtask

    task automatic dmi_read(input logic [6:0] a, output logic [31:0] d);
        @(negedge clk);
        dmi_bus.dmi_valid = 1'b1;
        dmi_bus.dmi_wr    = 1'b0;
        dmi_bus.dmi_addr  = a;
        @(negedge clk);
        dmi_bus.dmi_valid = 1'b0;
        d = dmi_bus.dmi_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dmi_bus.dmi_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 00000000", dmi_bus.dmi_rdata); end
        checks++; if ({halt_req, resume_req, ar_valid, ar_write, ndmreset} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {halt_req, resume_req, ar_valid, ar_write, ndmreset}); end
        checks++; if ({ar_regno, ar_wdata} !== 37'd0) begin errors++; $display("FAIL reset_ar: got regno %h wdata %h want 0", ar_regno, ar_wdata); end
        resetn = 1'b1;
        dmi_read(DM_DMSTATUS, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL inactive_dmstatus: got %h want 00000000", d); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        hart_halted = 1'b0;
        dmi_write(DM_DMCONTROL, 32'h0000_0001);
        dmi_read(DM_DMSTATUS, d);
        checks++; if (d !== 32'h0000_0C82) begin errors++; $display("FAIL dmstatus_running: got %h want 00000c82", d); end
        dmi_read(DM_ABSTRACTCS, d);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL abstractcs_idle: got %h want 00000001", d); end
        dmi_write(DM_DATA0, 32'h1234_5678);
        checks++; if (dmi_bus.dmi_rdata !== 32'h0000_0001) begin errors++; $display("FAIL rdata_hold: got %h want 00000001", dmi_bus.dmi_rdata); end
        dmi_read(DM_DATA0, d);
        checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL data0_rw: got %h want 12345678", d); end
        dmi_write(7'h20, 32'hFFFF_FFFF);
        dmi_read(7'h20, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL unmapped: got %h want 00000000", d); end
        dmi_read(DM_COMMAND, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL command_read: got %h want 00000000", d); end
    endtask

    task automatic test_halt();
        logic [31:0] d;
        dmi_write(DM_DMCONTROL, 32'h8000_0001);
        checks++; if (halt_req !== 1'b1) begin errors++; $display("FAIL halt_req: got %b want 1", halt_req); end
        hart_halted = 1'b1;
        dmi_read(DM_DMSTATUS, d);
        checks++; if (d !== 32'h0000_0382) begin errors++; $display("FAIL dmstatus_halted: got %h want 00000382", d); end
        dmi_write(DM_DMCONTROL, 32'h8000_0003);
        dmi_read(DM_DMCONTROL, d);
`ifdef DM_NDMRESET_EN
        checks++; if (d !== 32'h8000_0003 || ndmreset !== 1'b1) begin errors++; $display("FAIL ndmreset: got %h port %b want 80000003 port 1", d, ndmreset); end
`else
        checks++; if (d !== 32'h8000_0001 || ndmreset !== 1'b0) begin errors++; $display("FAIL ndmreset: got %h port %b want 80000001 port 0", d, ndmreset); end
`endif
        dmi_write(DM_DMCONTROL, 32'h8000_0001);
    endtask

    task automatic test_cmd_write();
        logic [31:0] d;
        dmi_write(DM_DATA0, 32'hDEAD_BEEF);
        dmi_write(DM_COMMAND, 32'h0023_1005);
        checks++; if ({ar_valid, ar_write, ar_regno} !== {1'b1, 1'b1, 5'd5}) begin errors++; $display("FAIL cmdw_launch: got v%b w%b r%0d want v1 w1 r5", ar_valid, ar_write, ar_regno); end
        checks++; if (ar_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cmdw_wdata: got %h want deadbeef", ar_wdata); end
        dmi_read(DM_ABSTRACTCS, d);
        checks++; if (d !== 32'h0000_1001) begin errors++; $display("FAIL cmdw_busy: got %h want 00001001", d); end
        dmi_write(DM_DATA0, 32'h1111_1111);
        dmi_read(DM_ABSTRACTCS, d);
        checks++; if (d !== 32'h0000_1101) begin errors++; $display("FAIL cmdw_busyerr: got %h want 00001101", d); end
        checks++; if (ar_valid !== 1'b1) begin errors++; $display("FAIL cmdw_hold: got %b want 1", ar_valid); end
        @(negedge clk); ar_ready = 1'b1;
        @(negedge clk); ar_ready = 1'b0;
        checks++; if (ar_valid !== 1'b0) begin errors++; $display("FAIL cmdw_done: got %b want 0", ar_valid); end
        dmi_read(DM_DATA0, d);
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cmdw_data0: got %h want deadbeef", d); end
        dmi_write(DM_ABSTRACTCS, 32'h0000_0100);
        dmi_read(DM_ABSTRACTCS, d);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL cmdw_w1c: got %h want 00000001", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        dmi_write(DM_COMMAND, 32'h0022_1008);
        checks++; if ({ar_valid, ar_write, ar_regno} !== {1'b1, 1'b0, 5'd8}) begin errors++; $display("FAIL cmdr_launch: got v%b w%b r%0d want v1 w0 r8", ar_valid, ar_write, ar_regno); end
        @(negedge clk); ar_ready = 1'b1; ar_rdata = 32'hCAFE_F00D;
        @(negedge clk); ar_ready = 1'b0;
        dmi_bus.dmi_valid = 1'b1; dmi_bus.dmi_wr = 1'b1;
        dmi_bus.dmi_addr = DM_COMMAND; dmi_bus.dmi_wdata = 32'h0023_100A;
        @(negedge clk); dmi_bus.dmi_valid = 1'b0; dmi_bus.dmi_wr = 1'b0;
        checks++; if ({ar_valid, ar_write, ar_regno} !== {1'b1, 1'b1, 5'd10}) begin errors++; $display("FAIL b2b_launch: got v%b w%b r%0d want v1 w1 r10", ar_valid, ar_write, ar_regno); end
        checks++; if (ar_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_wdata: got %h want cafef00d", ar_wdata); end
        @(negedge clk); ar_ready = 1'b1; ar_rdata = 32'h0BAD_0BAD;
        @(negedge clk); ar_ready = 1'b0;
        dmi_read(DM_DATA0, d);
        checks++; if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_data0: got %h want cafef00d", d); end
    endtask

    task automatic test_cmd_errors();
        logic [31:0] d;
        hart_halted = 1'b0;
        dmi_write(DM_COMMAND, 32'h0022_1001);
        checks++; if (ar_valid !== 1'b0) begin errors++; $display("FAIL err_running_valid: got %b want 0", ar_valid); end
        dmi_read(DM_ABSTRACTCS, d);
        checks++; if (d !== 32'h0000_0401) begin errors++; $display("FAIL err_running: got %h want 00000401", d); end
        hart_halted = 1'b1;
        dmi_write(DM_COMMAND, 32'h0023_1005);
        checks++; if (ar_valid !== 1'b0) begin errors++; $display("FAIL err_sticky: got %b want 0", ar_valid); end
        dmi_write(DM_ABSTRACTCS, 32'h0000_0700);
        dmi_read(DM_ABSTRACTCS, d);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL err_clear: got %h want 00000001", d); end
        dmi_write(DM_COMMAND, 32'h0032_1001);
        dmi_read(DM_ABSTRACTCS, d);
        checks++; if (d !== 32'h0000_0201) begin errors++; $display("FAIL err_aarsize: got %h want 00000201", d); end
        dmi_write(DM_ABSTRACTCS, 32'h0000_0700);
        dmi_write(DM_COMMAND, 32'h0022_1020);
        dmi_read(DM_ABSTRACTCS, d);
        checks++; if (d !== 32'h0000_0201) begin errors++; $display("FAIL err_regno: got %h want 00000201", d); end
        dmi_write(DM_ABSTRACTCS, 32'h0000_0700);
        dmi_write(DM_COMMAND, 32'h0122_1001);
        dmi_read(DM_ABSTRACTCS, d);
        checks++; if (d !== 32'h0000_0201) begin errors++; $display("FAIL err_cmdtype: got %h want 00000201", d); end
        dmi_write(DM_ABSTRACTCS, 32'h0000_0700);
        dmi_write(DM_COMMAND, 32'h0020_1001);
        checks++; if (ar_valid !== 1'b0) begin errors++; $display("FAIL notransfer_valid: got %b want 0", ar_valid); end
        dmi_read(DM_ABSTRACTCS, d);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL notransfer_cs: got %h want 00000001", d); end
    endtask

    task automatic test_resume();
        logic [31:0] d;
        hart_halted = 1'b1;
        dmi_write(DM_DMCONTROL, 32'h4000_0001);
        checks++; if ({halt_req, resume_req} !== 2'b01) begin errors++; $display("FAIL resume_set: got h%b r%b want h0 r1", halt_req, resume_req); end
        dmi_read(DM_DMCONTROL, d);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL resumereq_reads0: got %h want 00000001", d); end
        checks++; if (resume_req !== 1'b1) begin errors++; $display("FAIL resume_hold: got %b want 1", resume_req); end
        hart_halted = 1'b0;
        @(negedge clk);
        checks++; if (resume_req !== 1'b0) begin errors++; $display("FAIL resume_clear: got %b want 0", resume_req); end
        dmi_read(DM_DMSTATUS, d);
        checks++; if (d !== 32'h0003_0C82) begin errors++; $display("FAIL resumeack: got %h want 00030c82", d); end
        hart_halted = 1'b1;
        dmi_write(DM_DMCONTROL, 32'hC000_0001);
        checks++; if ({halt_req, resume_req} !== 2'b10) begin errors++; $display("FAIL resume_with_halt: got h%b r%b want h1 r0", halt_req, resume_req); end
        dmi_read(DM_DMSTATUS, d);
        checks++; if (d !== 32'h0003_0382) begin errors++; $display("FAIL resume_with_halt_ack: got %h want 00030382", d); end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        dmi_write(DM_DATA0, 32'h55AA_55AA);
        dmi_write(DM_COMMAND, 32'h0022_1003);
        checks++; if ({ar_valid, ar_write, ar_regno} !== {1'b1, 1'b0, 5'd3}) begin errors++; $display("FAIL abort_launch: got v%b w%b r%0d want v1 w0 r3", ar_valid, ar_write, ar_regno); end
        @(negedge clk);
        ar_ready = 1'b1; ar_rdata = 32'h9999_9999;
        dmi_bus.dmi_valid = 1'b1; dmi_bus.dmi_wr = 1'b1;
        dmi_bus.dmi_addr = DM_DMCONTROL; dmi_bus.dmi_wdata = 32'h0000_0000;
        @(negedge clk);
        ar_ready = 1'b0; dmi_bus.dmi_valid = 1'b0; dmi_bus.dmi_wr = 1'b0;
        checks++; if ({ar_valid, halt_req, resume_req, ndmreset} !== 4'b0) begin errors++; $display("FAIL abort_outputs: got %b want 0000", {ar_valid, halt_req, resume_req, ndmreset}); end
        dmi_read(DM_DMSTATUS, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL abort_dmstatus: got %h want 00000000", d); end
        dmi_read(DM_ABSTRACTCS, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL abort_abstractcs: got %h want 00000000", d); end
        dmi_read(DM_DATA0, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL abort_data0: got %h want 00000000", d); end
        dmi_write(DM_DATA0, 32'h7777_7777);
        dmi_write(DM_DMCONTROL, 32'h8000_0001);
        checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL inactive_haltreq: got %b want 0", halt_req); end
        dmi_read(DM_DMCONTROL, d);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL reactivate_ctrl: got %h want 00000001", d); end
        dmi_read(DM_DATA0, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reactivate_data0: got %h want 00000000", d); end
    endtask

    initial begin
        resetn            = 1'b0;
        hart_halted       = 1'b0;
        ar_ready          = 1'b0;
        ar_rdata          = 32'd0;
        dmi_bus.dmi_valid = 1'b0;
        dmi_bus.dmi_wr    = 1'b0;
        dmi_bus.dmi_addr  = 7'd0;
        dmi_bus.dmi_wdata = 32'd0;

        test_reset();
        test_regs();
        test_halt();
        test_cmd_write();
        test_back_to_back();
        test_cmd_errors();
        test_resume();
        test_abort();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
